// File: rtl/arith_pkg.sv
// arith_pkg: shared constants and helpers for the look-ahead adder family.
package arith_pkg;

    localparam int CLA_GROUP = 4;

    function automatic int num_groups(input int width);
        return width / CLA_GROUP;
    endfunction

endpackage

// File: rtl/cla_group_4.sv
// cla_group_4: combinational 4-bit look-ahead unit with flat carry equations.
module cla_group_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       G,
    output logic       P
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Each carry is a two-level sum of products; no carry feeds another.
    assign w_c[0] = c_in;
    assign w_c[1] = w_g[0] | (w_p[0] & c_in);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_in);

    assign s = w_p ^ w_c;
    assign G = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign P = &w_p;

endmodule

// File: rtl/cla_4bit.sv
// cla_4bit: registered carry-look-ahead adder built from 4-bit groups
// joined by a second-level look-ahead network.
module cla_4bit
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             pg,
    output logic             gg
);

    localparam int NG = num_groups(WIDTH);

    logic [NG-1:0]    w_g;
    logic [NG-1:0]    w_p;
    logic [NG:0]      w_gc;
    logic [WIDTH-1:0] w_sum;
    logic             w_gg;
    logic             w_gen;
    logic             w_span;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_pg;
    logic             r_gg;

    for (genvar j = 0; j < NG; j++) begin : g_grp
        cla_group_4 u_grp (
            .a    (a[4*j +: 4]),
            .b    (b[4*j +: 4]),
            .c_in (w_gc[j]),
            .s    (w_sum[4*j +: 4]),
            .G    (w_g[j]),
            .P    (w_p[j])
        );
    end

    // Group carries: w_gen is the cin-independent part, so the top one is gg.
    always_comb begin
        w_gc    = '0;
        w_gc[0] = cin;
        w_gg    = 1'b0;
        w_gen   = 1'b0;
        w_span  = 1'b0;
        for (int j = 0; j < NG; j++) begin
            w_gen = w_g[j];
            for (int k = 0; k < j; k++) begin
                w_span = w_g[k];
                for (int m = k + 1; m <= j; m++) w_span = w_span & w_p[m];
                w_gen = w_gen | w_span;
            end
            w_span = cin;
            for (int m = 0; m <= j; m++) w_span = w_span & w_p[m];
            w_gc[j+1] = w_gen | w_span;
            w_gg      = w_gen;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_pg   <= 1'b0;
            r_gg   <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_gc[NG];
            r_pg   <= &w_p;
            r_gg   <= w_gg;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign pg   = r_pg;
    assign gg   = r_gg;

endmodule

// File: tb/tb_cla_4bit.sv
// tb_cla_4bit: directed and random checks of cla_4bit against an arithmetic model.
module tb_cla_4bit;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         pg;
    logic         gg;

    int n_vec = 0;
    int n_err = 0;

    logic [W+2:0] exp_q;
    logic         have;
    logic [W-1:0] dir_a [7] = '{4'h0, 4'h3, 4'h7, 4'hF, 4'hA, 4'hF, 4'h0};
    logic [W-1:0] dir_b [7] = '{4'h0, 4'h5, 4'h1, 4'h1, 4'h5, 4'hF, 4'hF};
    logic         dir_c [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    cla_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .pg    (pg),
        .gg    (gg)
    );

    // {gg, pg, cout, sum} from plain integer arithmetic
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        int unsigned full;
        int unsigned nocarry;
        logic        prop;
        full    = int'(x) + int'(y) + int'(ci);
        nocarry = int'(x) + int'(y);
        prop    = ((x ^ y) == {W{1'b1}});
        return {nocarry >= (1 << W), prop, full >= (1 << W), full[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [W+2:0] obs, input logic [W+2:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: {gg,pg,cout,sum} got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        a     = x;
        b     = y;
        cin   = ci;
        exp_q = rst_n ? model(x, y, ci) : '0;
        have  = 1'b1;
    endtask

    initial begin
        have = 1'b0;
        @(negedge clk);
        check("reset_init", {gg, pg, cout, sum}, '0);
        rst_n = 1'b1;
        drive(4'h3, 4'h5, 1'b0);
        @(negedge clk);
        check("pre_reset", {gg, pg, cout, sum}, exp_q);
        drive(4'h7, 4'h1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("reset_async", {gg, pg, cout, sum}, '0);
        @(negedge clk);
        check("reset_hold", {gg, pg, cout, sum}, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(dir_a[i], dir_b[i], dir_c[i]);
            @(negedge clk);
            check($sformatf("dir%0d", i), {gg, pg, cout, sum}, exp_q);
        end
        have = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (have) check("rand", {gg, pg, cout, sum}, exp_q);
            if (i == 100) begin
                rst_n = 1'b0;
                #1 check("rand_rst_async", {gg, pg, cout, sum}, '0);
            end
            if (i == 103) rst_n = 1'b1;
            drive(W'($urandom), W'($urandom), 1'($urandom));
        end
        @(negedge clk);
        check("rand_last", {gg, pg, cout, sum}, exp_q);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
